sha256_msg_padder: RTL and testbench

Byte-stream front end for the SHA-256 compression core. Accepts message bytes over a valid/ready handshake, packs them big-endian into 512-bit blocks, appends FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length) and emits each block as 16 word-serial 32-bit words. Sits directly upstream of the compression core, which loads the 16 words into its schedule buffer.

---
 rtl/sha256_msg_padder.sv | 168 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 front end: packs message bytes big-endian into 512-bit blocks, appends 0x80/zero/length padding, emits 16 words per block.
// One byte per cycle in FILL, PAD and LEN; in_ready is low outside FILL; out_ready low holds the current word and its flags stable.
module sha256_msg_padder #(
  parameter int LEN_W = 61
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_nodata,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sob,
  output logic        out_eob,
  output logic        out_final
);

  typedef enum logic [2:0] {S_FILL, S_PAD80, S_PADZ, S_LEN, S_EMIT} state_t;

  state_t           state_q, resume_q;
  logic [5:0]       pos_q;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       widx_q;
  logic             pad_lo_q;
  logic             in_ready_q, out_valid_q, final_q;
  logic [7:0]       buf_q [64];

  logic             wr_en;
  logic [7:0]       wr_byte;
  logic [63:0]      len_bits;
  logic             accept;

  assign len_bits = 64'({len_q, 3'b000});
  assign accept   = in_valid && in_ready_q;

  always_comb begin
    wr_en   = 1'b0;
    wr_byte = 8'h00;
    case (state_q)
      S_FILL: begin
        wr_en   = accept && !(in_last && in_nodata);
        wr_byte = in_data;
      end
      S_PAD80: begin
        wr_en   = 1'b1;
        wr_byte = 8'h80;
      end
      S_PADZ: wr_en = 1'b1;
      S_LEN: begin
        wr_en   = 1'b1;
        // pos 56 carries the most significant length byte
        wr_byte = len_bits[{~pos_q[2:0], 3'b000} +: 8];
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[pos_q] <= wr_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      resume_q    <= S_FILL;
      pos_q       <= '0;
      len_q       <= '0;
      widx_q      <= '0;
      pad_lo_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          pad_lo_q   <= 1'b0;
          if (accept) begin
            if (in_last && in_nodata) begin
              in_ready_q <= 1'b0;
              state_q    <= S_PAD80;
            end else begin
              pos_q <= pos_q + 6'd1;
              len_q <= len_q + LEN_W'(1);
              if (pos_q == 6'd63) begin
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                final_q     <= 1'b0;
                resume_q    <= in_last ? S_PAD80 : S_FILL;
                state_q     <= S_EMIT;
              end else if (in_last) begin
                in_ready_q <= 1'b0;
                state_q    <= S_PAD80;
              end
            end
          end
        end
        S_PAD80: begin
          pos_q <= pos_q + 6'd1;
          if (pos_q <= 6'd55) pad_lo_q <= 1'b1;
          if (pos_q == 6'd55) begin
            state_q <= S_LEN;
          end else if (pos_q == 6'd63) begin
            // 0x80 filled the block: the next block is zeros plus length
            pad_lo_q    <= 1'b1;
            out_valid_q <= 1'b1;
            final_q     <= 1'b0;
            resume_q    <= S_PADZ;
            state_q     <= S_EMIT;
          end else begin
            state_q <= S_PADZ;
          end
        end
        S_PADZ: begin
          pos_q <= pos_q + 6'd1;
          if (pos_q == 6'd55 && pad_lo_q) begin
            state_q <= S_LEN;
          end else if (pos_q == 6'd63) begin
            pad_lo_q    <= 1'b1;
            out_valid_q <= 1'b1;
            final_q     <= 1'b0;
            resume_q    <= S_PADZ;
            state_q     <= S_EMIT;
          end
        end
        S_LEN: begin
          pos_q <= pos_q + 6'd1;
          if (pos_q == 6'd63) begin
            out_valid_q <= 1'b1;
            final_q     <= 1'b1;
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            widx_q <= widx_q + 4'd1;
            if (widx_q == 4'd15) begin
              out_valid_q <= 1'b0;
              pos_q       <= '0;
              if (final_q) begin
                final_q    <= 1'b0;
                len_q      <= '0;
                in_ready_q <= 1'b1;
                state_q    <= S_FILL;
              end else begin
                in_ready_q <= (resume_q == S_FILL);
                state_q    <= resume_q;
              end
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_valid_q ? {buf_q[{widx_q, 2'b00}], buf_q[{widx_q, 2'b01}],
                                    buf_q[{widx_q, 2'b10}], buf_q[{widx_q, 2'b11}]} : 32'h0;
  assign out_sob   = out_valid_q && (widx_q == 4'd0);
  assign out_eob   = out_valid_q && (widx_q == 4'd15);
  assign out_final = out_valid_q && final_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks, stalls and mid-emit reset.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_nodata;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid, out_ready;
  logic        out_sob, out_eob, out_final;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_w [16];
  int lat;

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_nodata (in_nodata),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .out_final (out_final)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
  endtask

  // Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic nodata);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = last; in_nodata = nodata;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 64'(n < 300), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_nodata = 1'b0; in_data = 8'h00;
  endtask

  task automatic recv_block(input string tag, input logic exp_final, input logic stall,
                            output int wait_cycles);
    int n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    wait_cycles = n;
    chk($sformatf("%s_valid", tag), 64'(out_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_w%0d", tag, i), 64'(out_word), 64'(exp_w[i]));
      chk($sformatf("%s_sob%0d", tag, i), 64'(out_sob), 64'(i == 0));
      chk($sformatf("%s_eob%0d", tag, i), 64'(out_eob), 64'(i == 15));
      chk($sformatf("%s_fin%0d", tag, i), 64'(out_final), 64'(exp_final));
      chk($sformatf("%s_inrdy%0d", tag, i), 64'(in_ready), 64'd0);
      if (stall) begin
        for (int s = 0; s < 4 && $urandom_range(0, 1) == 0; s++) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk($sformatf("%s_stl_v%0d", tag, i), 64'(out_valid), 64'd1);
          chk($sformatf("%s_stl_w%0d", tag, i), 64'(out_word), 64'(exp_w[i]));
          chk($sformatf("%s_stl_sob%0d", tag, i), 64'(out_sob), 64'(i == 0));
          chk($sformatf("%s_stl_eob%0d", tag, i), 64'(out_eob), 64'(i == 15));
          chk($sformatf("%s_stl_fin%0d", tag, i), 64'(out_final), 64'(exp_final));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk($sformatf("%s_vld_drop", tag), 64'(out_valid), 64'd0);
    if (exp_final) chk($sformatf("%s_inrdy_back", tag), 64'(in_ready), 64'd1);
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
  endtask

  task automatic exp_abc();
    clear_exp();
    exp_w[0]  = 32'h61626380;
    exp_w[15] = 32'h00000018;
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_nodata = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_flags", 64'({out_sob, out_eob, out_final}), 64'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // "abc" with latency check: valid after edge 61 following the last byte
    send_abc();
    exp_abc();
    recv_block("abc", 1'b1, 1'b0, lat);
    chk("abc_latency", 64'(lat), 64'd61);

    // zero-length message; in_data must be ignored
    send_byte(8'hFF, 1'b1, 1'b1);
    clear_exp();
    exp_w[0] = 32'h80000000;
    recv_block("empty", 1'b1, 1'b0, lat);

    // 56 zero bytes: padding spills into a second block
    for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55, 1'b0);
    clear_exp();
    exp_w[14] = 32'h80000000;
    recv_block("z56_b1", 1'b0, 1'b0, lat);
    clear_exp();
    exp_w[15] = 32'h000001C0;
    recv_block("z56_b2", 1'b1, 1'b0, lat);

    // 64 bytes 0x00..0x3F: full data block, then a padding-only block
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63, 1'b0);
    for (int k = 0; k < 16; k++)
      exp_w[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    recv_block("s64_b1", 1'b0, 1'b0, lat);
    chk("s64_inrdy_after_b1", 64'(in_ready), 64'd0);
    clear_exp();
    exp_w[0]  = 32'h80000000;
    exp_w[15] = 32'h00000200;
    recv_block("s64_b2", 1'b1, 1'b0, lat);

    // "abc" with pseudo-random output stalls
    send_abc();
    exp_abc();
    recv_block("abc_stall", 1'b1, 1'b1, lat);

    // reset while word 7 is presented
    send_abc();
    lat = 0;
    while (!out_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("pre_rst_w7", 64'(out_word), 64'd0);
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    chk("mid_rst_flags", 64'({out_sob, out_eob, out_final}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_hold_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_no_out", 64'(out_valid), 64'd0);
    send_abc();
    exp_abc();
    recv_block("abc_post_rst", 1'b1, 1'b0, lat);
    chk("abc_post_rst_latency", 64'(lat), 64'd61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
